sram_axi_arb: RTL and testbench

SRAM_AXI_ARB -- requirements
Module: sram_axi_arb

---
 rtl/sram_axi_arb.sv | 184 ++++++++++++++++++
 tb/tb_sram_axi_arb.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_arb.sv
// Two-master round-robin arbiter in front of a single AXI-lite SRAM port.
// One transaction (write or read) owns the slave port from grant to completion.
module sram_axi_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [1:0]          gnt,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t state, state_nxt;
  logic [1:0] gnt_nxt;
  logic       ptr, ptr_nxt;
  logic       wr0, wr1, req0, req1;
  logic       win, win_wr, sel;
  logic       aw_rdy, w_rdy, ar_rdy, r_vld;
  logic [DATA_W-1:0] r_data;

  assign wr0  = m0_awvalid & m0_wvalid;
  assign wr1  = m1_awvalid & m1_wvalid;
  assign req0 = wr0 | m0_arvalid;
  assign req1 = wr1 | m1_arvalid;
  assign sel  = gnt[1];
  assign busy = (state != IDLE);

  // ptr holds the last winner; on a tie the other master goes next
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      req0 & req1:  win = ~ptr;
      req1 & ~req0: win = 1'b1;
      default:      win = 1'b0;
    endcase
  end

  assign win_wr = win ? wr1 : wr0;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        gnt_nxt = 2'b00;
        if (req0 | req1) begin
          gnt_nxt   = win ? 2'b10 : 2'b01;
          ptr_nxt   = win;
          state_nxt = win_wr ? WRITE : RD_ADDR;
        end
      end
      WRITE: begin
        if (s_awvalid & s_awready & s_wvalid & s_wready) begin
          state_nxt = IDLE;
          gnt_nxt   = 2'b00;
        end
      end
      RD_ADDR: begin
        if (s_arvalid & s_arready)
          state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (s_rvalid & s_rready) begin
          state_nxt = IDLE;
          gnt_nxt   = 2'b00;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 2'b00;
      ptr   <= 1'b1;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = 1'b0;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    aw_rdy    = 1'b0;
    w_rdy     = 1'b0;
    ar_rdy    = 1'b0;
    r_vld     = 1'b0;
    r_data    = '0;
    unique case (state)
      WRITE: begin
        s_awaddr  = sel ? m1_awaddr  : m0_awaddr;
        s_awvalid = sel ? m1_awvalid : m0_awvalid;
        s_wdata   = sel ? m1_wdata   : m0_wdata;
        s_wstrb   = sel ? m1_wstrb   : m0_wstrb;
        s_wvalid  = sel ? m1_wvalid  : m0_wvalid;
        aw_rdy    = s_awready;
        w_rdy     = s_wready;
      end
      RD_ADDR: begin
        s_araddr  = sel ? m1_araddr  : m0_araddr;
        s_arvalid = sel ? m1_arvalid : m0_arvalid;
        ar_rdy    = s_arready;
      end
      RD_DATA: begin
        s_rready  = sel ? m1_rready : m0_rready;
        r_vld     = s_rvalid;
        r_data    = s_rdata;
      end
      default: begin
      end
    endcase
  end

  assign m0_awready = aw_rdy & ~sel;
  assign m0_wready  = w_rdy  & ~sel;
  assign m0_arready = ar_rdy & ~sel;
  assign m0_rvalid  = r_vld  & ~sel;
  assign m0_rdata   = sel ? '0 : r_data;
  assign m1_awready = aw_rdy & sel;
  assign m1_wready  = w_rdy  & sel;
  assign m1_arready = ar_rdy & sel;
  assign m1_rvalid  = r_vld  & sel;
  assign m1_rdata   = sel ? r_data : '0;

endmodule

// File: tb/tb_sram_axi_arb.sv
// Bench for sram_axi_arb: two driven masters, a behavioural SRAM slave
// and a transaction-level owner/pointer/memory reference model.
module tb_sram_axi_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] awa[2], ara[2], wd[2];
  logic [3:0]  ws[2];
  logic        awv[2], wv[2], arv[2], rr[2];
  logic        awr_o[2], wr_o[2], arr_o[2], rv_o[2];
  logic [31:0] rd_o[2];

  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic s_awvalid, s_awready, s_wvalid, s_wready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  gnt;
  logic        busy;

  logic        sl_wrdy = 1'b1;
  logic        sl_ardy = 1'b1;
  logic [31:0] mem_s[16];

  assign s_awready = sl_wrdy;
  assign s_wready  = sl_wrdy;
  assign s_arready = sl_ardy;

  sram_axi_arb dut (
    .clk(clk), .rst_n(rst_n),
    .m0_awaddr(awa[0]), .m0_awvalid(awv[0]), .m0_awready(awr_o[0]),
    .m0_wdata(wd[0]), .m0_wstrb(ws[0]), .m0_wvalid(wv[0]),
    .m0_wready(wr_o[0]),
    .m0_araddr(ara[0]), .m0_arvalid(arv[0]), .m0_arready(arr_o[0]),
    .m0_rdata(rd_o[0]), .m0_rvalid(rv_o[0]), .m0_rready(rr[0]),
    .m1_awaddr(awa[1]), .m1_awvalid(awv[1]), .m1_awready(awr_o[1]),
    .m1_wdata(wd[1]), .m1_wstrb(ws[1]), .m1_wvalid(wv[1]),
    .m1_wready(wr_o[1]),
    .m1_araddr(ara[1]), .m1_arvalid(arv[1]), .m1_arready(arr_o[1]),
    .m1_rdata(rd_o[1]), .m1_rvalid(rv_o[1]), .m1_rready(rr[1]),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .gnt(gnt), .busy(busy)
  );

  // SRAM slave, reset by the same rst_n
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
    end else begin
      if (s_awvalid && s_awready && s_wvalid && s_wready)
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b])
            mem_s[s_awaddr[5:2]][b*8 +: 8] <= s_wdata[b*8 +: 8];
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem_s[s_araddr[5:2]];
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  int          tests = 0;
  int          fails = 0;
  int          owner;
  int          phase;
  bit          ptr;
  logic [31:0] mem_m[16];
  int          waitg[2];
  bit          rwait[2];
  int          rhold[2];
  int          auto_n[2];
  bit          auto_rnd[2];
  logic [31:0] auto_addr[2];
  bit          rnd_slave = 1'b0;
  logic [1:0]  gq[$];
  logic [1:0]  gprev;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
      input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic bit m_idle(input int n);
    return !awv[n] && !wv[n] && !arv[n] && !rwait[n];
  endfunction

  function automatic bit all_idle();
    return owner < 0 && m_idle(0) && m_idle(1) &&
           auto_n[0] == 0 && auto_n[1] == 0;
  endfunction

  task automatic issue_wr(input int n, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    awv[n] = 1'b1; wv[n] = 1'b1;
    awa[n] = a; wd[n] = d; ws[n] = s;
  endtask

  task automatic issue_rd(input int n, input logic [31:0] a);
    arv[n] = 1'b1; ara[n] = a;
  endtask

  task automatic auto_issue(input int n);
    int k;
    if (!auto_rnd[n]) begin
      issue_rd(n, auto_addr[n]);
    end else begin
      k = $urandom_range(0, 2);
      if (k != 1)
        issue_wr(n, {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                 $urandom, 4'($urandom_range(1, 15)));
      if (k != 0)
        issue_rd(n, {26'd0, 4'($urandom_range(0, 15)), 2'b00});
      rhold[n] = $urandom_range(0, 3);
    end
  endtask

  // One clock cycle: check outputs against the model, then advance it.
  task automatic step();
    int n_owner, n_phase, w, o;
    bit n_ptr, mw;
    bit rq[2], c_aw[2], c_w[2], c_ar[2], rdone[2], dec[2];
    logic [3:0]  mi;
    logic [31:0] md;
    logic [1:0]  eg;
    #1;
    n_owner = owner; n_phase = phase; n_ptr = ptr;
    mw = 1'b0; mi = '0; md = '0;
    eg = (owner < 0) ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10);
    chk("gnt", gnt, eg);
    chk("busy", busy, owner >= 0);
    if (gnt != 2'b00 && gprev == 2'b00) gq.push_back(gnt);
    gprev = gnt;
    for (int n = 0; n < 2; n++)
      if (owner != n)
        chk($sformatf("m%0d_quiet", n),
            {awr_o[n], wr_o[n], arr_o[n], rv_o[n], rd_o[n]}, 0);
    if (owner < 0) begin
      chk("s_idle", {s_awvalid, s_wvalid, s_arvalid, s_rready}, 0);
      chk("s_idle_bus", {s_awaddr, s_araddr, s_wdata, s_wstrb}, 0);
      for (int n = 0; n < 2; n++) begin
        rq[n] = (awv[n] & wv[n]) | arv[n];
        if (!rq[n]) waitg[n] = 0;
      end
      if (rq[0] | rq[1]) begin
        w = (rq[0] & rq[1]) ? (ptr ? 0 : 1) : (rq[0] ? 0 : 1);
        n_owner = w;
        n_ptr = w[0];
        n_phase = (awv[w] & wv[w]) ? 0 : 1;
        if (rq[1-w]) begin
          waitg[1-w]++;
          chk("fairness", waitg[1-w] <= 1, 1);
        end
        waitg[w] = 0;
      end
    end else begin
      o = owner;
      case (phase)
        0: begin
          chk("wr_fwd",
              {s_awvalid, s_wvalid, s_arvalid, s_wstrb, s_awaddr, s_wdata},
              {awv[o], wv[o], 1'b0, ws[o], awa[o], wd[o]});
          chk("wr_rdy", {awr_o[o], wr_o[o], arr_o[o]},
              {sl_wrdy, sl_wrdy, 1'b0});
          if (awv[o] & wv[o] & sl_wrdy) begin
            n_owner = -1;
            mw = 1'b1;
            mi = awa[o][5:2];
            md = merge(mem_m[awa[o][5:2]], wd[o], ws[o]);
          end
        end
        1: begin
          chk("ra_fwd", {s_awvalid, s_wvalid, s_arvalid, s_araddr},
              {2'b00, arv[o], ara[o]});
          chk("ra_rdy", {awr_o[o], wr_o[o], arr_o[o]}, {2'b00, sl_ardy});
          if (arv[o] & sl_ardy) n_phase = 2;
        end
        default: begin
          chk("rd_fwd", {s_arvalid, s_rready, rv_o[o]},
              {1'b0, rr[o], s_rvalid});
          if (s_rvalid) chk("rdata", rd_o[o], mem_m[ara[o][5:2]]);
          if (s_rvalid & rr[o]) n_owner = -1;
        end
      endcase
    end
    for (int n = 0; n < 2; n++) begin
      c_aw[n]  = awv[n] & awr_o[n];
      c_w[n]   = wv[n] & wr_o[n];
      c_ar[n]  = arv[n] & arr_o[n];
      rdone[n] = rwait[n] & rv_o[n] & rr[n];
      dec[n]   = rwait[n] & rv_o[n] & (rhold[n] > 0);
    end
    @(posedge clk);
    @(negedge clk);
    owner = n_owner; phase = n_phase; ptr = n_ptr;
    if (mw) mem_m[mi] = md;
    for (int n = 0; n < 2; n++) begin
      if (c_aw[n]) awv[n] = 1'b0;
      if (c_w[n]) wv[n] = 1'b0;
      if (c_ar[n]) begin arv[n] = 1'b0; rwait[n] = 1'b1; end
      if (rdone[n]) rwait[n] = 1'b0;
      if (dec[n]) rhold[n]--;
      if (auto_n[n] > 0 && m_idle(n)) begin
        auto_n[n]--;
        auto_issue(n);
      end
      rr[n] = rwait[n] && rhold[n] == 0;
    end
    if (rnd_slave) begin
      sl_wrdy = $urandom_range(0, 3) != 0;
      sl_ardy = $urandom_range(0, 3) != 0;
    end
  endtask

  task automatic run_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (all_idle()) break;
      step();
    end
    chk("drain", all_idle(), 1);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      awv[n] = 1'b0; wv[n] = 1'b0; arv[n] = 1'b0; rr[n] = 1'b0;
      rwait[n] = 1'b0; rhold[n] = 0; auto_n[n] = 0; waitg[n] = 0;
      awa[n] = '0; ara[n] = '0; wd[n] = '0; ws[n] = '0;
    end
    owner = -1; phase = 0; ptr = 1'b1; gprev = 2'b00;
    @(negedge clk);
    #1;
    chk("rst_gnt_busy", {gnt, busy}, 0);
    chk("rst_s", {s_awvalid, s_wvalid, s_arvalid, s_rready,
                  s_awaddr, s_araddr, s_wdata, s_wstrb}, 0);
    chk("rst_m", {awr_o[0], wr_o[0], arr_o[0], rv_o[0], rd_o[0],
                  awr_o[1], wr_o[1], arr_o[1], rv_o[1], rd_o[1]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_s[i] = '0;
      mem_m[i] = '0;
    end
    auto_rnd[0] = 1'b0; auto_rnd[1] = 1'b0;
    auto_addr[0] = '0; auto_addr[1] = '0;
    do_reset();

    // single uncontended write
    issue_wr(0, 32'h10, 32'hDEADBEEF, 4'hF);
    step();
    #1;
    chk("w_gnt", gnt, 2'b01);
    chk("w_hs", {s_awvalid & s_awready & s_wvalid & s_wready,
                 awr_o[0], wr_o[0]}, 3'b111);
    step();
    #1;
    chk("w_done", {busy, gnt, awr_o[0], wr_o[0]}, 0);

    // m1 reads it back
    issue_rd(1, 32'h10);
    step();
    #1;
    chk("r_gnt", gnt, 2'b10);
    chk("r_addr", {s_arvalid, s_araddr}, {1'b1, 32'h10});
    step();
    #1;
    chk("r_data", {rv_o[1], rd_o[1]}, {1'b1, 32'hDEADBEEF});
    chk("r_m0_quiet", rv_o[0], 1'b0);
    step();
    #1;
    chk("r_done", busy, 1'b0);

    // continuous contending reads alternate, m0 first after reset
    do_reset();
    gq.delete();
    auto_addr[0] = 32'h0; auto_addr[1] = 32'h4;
    issue_rd(0, 32'h0); issue_rd(1, 32'h4);
    auto_n[0] = 3; auto_n[1] = 3;
    run_idle(300);
    chk("rr_count", gq.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rr_gnt%0d", i), gq[i],
          (i % 2 == 1) ? 2'b10 : 2'b01);

    // m0 stalls its read data, m1's write waits
    gq.delete();
    rhold[0] = 5;
    issue_rd(0, 32'h10);
    step();
    step();
    issue_wr(1, 32'h14, 32'hA5A50000, 4'hC);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d", i),
          {gnt, busy, rv_o[0], rd_o[0], rr[0], awr_o[1]},
          {2'b01, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0});
      step();
    end
    run_idle(100);
    chk("stall_n", gq.size(), 2);
    chk("stall_g0", gq[0], 2'b01);
    chk("stall_g1", gq[1], 2'b10);

    // write beats read from the same master
    gq.delete();
    issue_wr(0, 32'h20, 32'hCAFEF00D, 4'hF);
    issue_rd(0, 32'h20);
    step();
    #1;
    chk("wfirst", {s_awvalid, s_arvalid}, 2'b10);
    run_idle(100);
    chk("wfirst_n", gq.size(), 2);
    chk("wfirst_g0", gq[0], 2'b01);
    chk("wfirst_g1", gq[1], 2'b01);

    // reset in the middle of a stalled write
    sl_wrdy = 1'b0;
    issue_wr(0, 32'h8, 32'h12345678, 4'hF);
    step();
    step();
    #1;
    chk("mid_busy", {gnt, busy, s_awvalid}, {2'b01, 1'b1, 1'b1});
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {gnt, busy, s_awvalid, s_wvalid, awr_o[0], wr_o[0],
                    s_awaddr, s_wdata}, 0);
    do_reset();
    sl_wrdy = 1'b1;
    issue_wr(0, 32'h30, 32'h11112222, 4'hF);
    issue_wr(1, 32'h34, 32'h33334444, 4'hF);
    step();
    #1;
    chk("post_rst_tie", gnt, 2'b01);
    run_idle(100);

    // randomized traffic with random slave backpressure
    rnd_slave = 1'b1;
    auto_rnd[0] = 1'b1; auto_rnd[1] = 1'b1;
    auto_n[0] = 40; auto_n[1] = 40;
    run_idle(5000);
    rnd_slave = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
